// File: rtl/instr_fetch_unit.sv
// Instruction fetch: fetch PC, single-outstanding imem request FSM, and an {instr, PC} buffer to decode.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds Fetch_Misaligned_o and halts fetch on a misaligned redirect.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0040_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Redirect_i,
   input  logic [31:0] Redirect_PC_i,
   output logic        Imem_Req_o,
   output logic [31:0] Imem_Addr_o,
   input  logic        Imem_Ack_i,
   input  logic        Imem_Rvalid_i,
   input  logic [31:0] Imem_Rdata_i,
   output logic        Instr_Valid_o,
   output logic [31:0] Instr_o,
   output logic [31:0] Instr_PC_o,
   input  logic        Instr_Ready_i
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        Fetch_Misaligned_o
`endif
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        req_pc_q;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               halted_q, halted_d;
   logic [31:0]        fifo_instr_q [FIFO_DEPTH];
   logic [31:0]        fifo_pc_q    [FIFO_DEPTH];
   logic [31:0]        redir_pc;
   logic               redir_bad;
   logic               issue, push, pop;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign redir_pc           = Redirect_PC_i;
   assign redir_bad          = (Redirect_PC_i[1:0] != 2'b00);
   assign Fetch_Misaligned_o = halted_q;
`else
   logic unused_pc_bits;
   assign redir_pc       = {Redirect_PC_i[31:2], 2'b00};
   assign redir_bad      = 1'b0;
   assign unused_pc_bits = ^Redirect_PC_i[1:0];
`endif

   always_comb begin
      Imem_Req_o    = !reset && !Redirect_i && !halted_q &&
                      (state_q == S_IDLE) && (count_q < DEPTH_C);
      Imem_Addr_o   = pc_q;
      Instr_Valid_o = !reset && !Redirect_i && (count_q != '0);
      Instr_o       = '0;
      Instr_PC_o    = '0;
      if (!reset && (count_q != '0)) begin
         Instr_o    = fifo_instr_q[rd_ptr_q];
         Instr_PC_o = fifo_pc_q[rd_ptr_q];
      end

      issue = Imem_Req_o && Imem_Ack_i;
      push  = (state_q == S_WAIT) && Imem_Rvalid_i && !Redirect_i;
      pop   = Instr_Valid_o && Instr_Ready_i;

      state_d  = state_q;
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      halted_d = halted_q;

      if (Redirect_i) begin
         // Flush wins over everything; a response still in flight must be swallowed in DROP.
         pc_d     = redir_pc;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         halted_d = halted_q | redir_bad;
         unique case (state_q)
            S_WAIT:  state_d = Imem_Rvalid_i ? S_IDLE : S_DROP;
            S_DROP:  state_d = Imem_Rvalid_i ? S_IDLE : S_DROP;
            default: state_d = S_IDLE;
         endcase
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (!push && pop) count_d = count_q - 1'b1;
         unique case (state_q)
            S_IDLE: begin
               if (issue) begin
                  pc_d    = pc_q + 32'd4;
                  state_d = S_WAIT;
               end
            end
            S_WAIT:  if (Imem_Rvalid_i) state_d = S_IDLE;
            S_DROP:  if (Imem_Rvalid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         halted_q <= halted_d;
      end
   end

   // Buffer contents carry no reset; the head is only exposed while count is nonzero.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_q[wr_ptr_q] <= Imem_Rdata_i;
         fifo_pc_q[wr_ptr_q]    <= req_pc_q;
      end
      if (issue) req_pc_q <= pc_q;
   end
endmodule
